// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, ASCII command constants and segment table
//
// Contents:
//   rd_state_e   read FSM states (IDLE, POP, LAT, CAP)
//   ZERO..LF     ASCII bytes recognised by the command decoder
//   SEG_TABLE    active-low common-anode codes for digits 0..9 (dp off)
//   SEG_BLANK    all segments off
//   seg_code()   BCD digit to segment byte, blank for non-decimal nibbles
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_LAT,
    ST_CAP
  } rd_state_e;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] CLR_U = 8'h43;
  localparam logic [7:0] CLR_L = 8'h63;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam logic [2:0] NDIG_MAX = 3'd6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry [d] holds the pattern for digit d.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    code = SEG_BLANK;
    if (d <= 4'd9) code = SEG_TABLE[d];
    return code;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit display multiplexer with segment decode
//
// Optional feature macro: SEG_LZ_BLANK_EN (blank leading digits beyond ndig)
//
// Ports:
//   clk, sys_rst_n  clock, asynchronous active-low reset
//   disp_bcd_i      24-bit BCD value, digit i in bits [4i+3:4i]
//   ndig_i          valid digit count (only with SEG_LZ_BLANK_EN)
//   seg_sel_o       active-low one-hot digit select, bit 0 rightmost
//   seg_led_o       active-low segments {dp, g..a}, dp always off
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [23:0] disp_bcd_i,
`ifdef SEG_LZ_BLANK_EN
  input  logic [2:0]  ndig_i,
`endif
  output logic [5:0]  seg_sel_o,
  output logic [7:0]  seg_led_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       seg_sel_q;
  logic [7:0]       seg_led_q;
  logic [3:0]       digit;
  logic [7:0]       code;
  logic             blank;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = disp_bcd_i[3:0];
      3'd1:    digit = disp_bcd_i[7:4];
      3'd2:    digit = disp_bcd_i[11:8];
      3'd3:    digit = disp_bcd_i[15:12];
      3'd4:    digit = disp_bcd_i[19:16];
      3'd5:    digit = disp_bcd_i[23:20];
      default: digit = 4'd0;
    endcase
    code = seg_code(digit);
  end

`ifdef SEG_LZ_BLANK_EN
  // Digit 0 is always lit so an empty register still reads "0".
  logic [2:0] nshow;
  always_comb begin
    nshow = (ndig_i == 3'd0) ? 3'd1 : ndig_i;
    blank = (idx_q >= nshow);
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q     <= '0;
      idx_q     <= 3'd0;
      seg_sel_q <= 6'b111111;
      seg_led_q <= SEG_BLANK;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_sel_q <= ~(6'b000001 << idx_q);
      seg_led_q <= blank ? SEG_BLANK : {1'b1, code[6:0]};
    end
  end

  assign seg_sel_o = seg_sel_q;
  assign seg_led_o = seg_led_q;

endmodule

// File: rtl/seg_fifo_ctrl.sv
// rtl/seg_fifo_ctrl.sv - UART RX FIFO reader, ASCII digit command decoder, display driver
//
// Optional feature macro: SEG_LZ_BLANK_EN (blank leading digits on the display)
//
// Ports:
//   clk, sys_rst_n  clock, asynchronous active-low reset
//   fifo_empty      FIFO empty flag, sampled only while idle
//   fifo_q          FIFO read data, valid the cycle after rdreq is sampled
//   fifo_rdreq      one-cycle pop strobe
//   seg_sel         active-low one-hot digit select, bit 0 rightmost
//   seg_led         active-low segments {dp, g..a}
//   disp_bcd        6-digit BCD register
//   byte_err        one-cycle pulse after an unrecognised byte is consumed
module seg_fifo_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led,
  output logic [23:0] disp_bcd,
  output logic        byte_err
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;

  rd_state_e   state_q;
  logic        rdreq_q;
  logic        byte_err_q;
  logic [23:0] bcd_q;
  logic [2:0]  ndig_q;

  // rdreq is raised on the IDLE->POP transition so it is high during POP.
  // LAT covers the FIFO read latency; fifo_q is held stable through CAP.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      rdreq_q    <= 1'b0;
      byte_err_q <= 1'b0;
      bcd_q      <= '0;
      ndig_q     <= 3'd0;
    end else begin
      rdreq_q    <= 1'b0;
      byte_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_POP;
            rdreq_q <= 1'b1;
          end
        end
        ST_POP: state_q <= ST_LAT;
        ST_LAT: state_q <= ST_CAP;
        ST_CAP: begin
          state_q <= ST_IDLE;
          if (fifo_q >= ZERO && fifo_q <= NINE) begin
            // Low nibble of an ASCII digit is its BCD value.
            bcd_q <= {bcd_q[19:0], fifo_q[3:0]};
            if (ndig_q != NDIG_MAX) ndig_q <= ndig_q + 3'd1;
          end else if (fifo_q == CLR_U || fifo_q == CLR_L) begin
            bcd_q  <= '0;
            ndig_q <= 3'd0;
          end else if (fifo_q != CR && fifo_q != LF) begin
            byte_err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign byte_err   = byte_err_q;
  assign disp_bcd   = bcd_q;

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .disp_bcd_i(bcd_q),
`ifdef SEG_LZ_BLANK_EN
    .ndig_i    (ndig_q),
`endif
    .seg_sel_o (seg_sel),
    .seg_led_o (seg_led)
  );

endmodule

// File: tb/tb_seg_fifo_ctrl.sv
// tb/tb_seg_fifo_ctrl.sv - directed self-checking bench for seg_fifo_ctrl
module tb_seg_fifo_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic [23:0] disp_bcd;
  logic        byte_err;

  always #5 clk = ~clk;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  seg_fifo_ctrl #(
    .CLK_FREQ(1000),
    .SCAN_HZ (250)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .fifo_empty(fifo_empty),
    .fifo_q    (fifo_q),
    .fifo_rdreq(fifo_rdreq),
    .seg_sel   (seg_sel),
    .seg_led   (seg_led),
    .disp_bcd  (disp_bcd),
    .byte_err  (byte_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: data appears on fifo_q the cycle after rdreq is sampled and holds.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_pop = -100;

  always @(posedge clk) begin
    cyc++;
    if (byte_err) err_cnt++;
    if (fifo_rdreq) begin
      pop_cnt++;
      chk("rd_gap", 32'((cyc - last_pop) >= 4), 32'd1);
      last_pop = cyc;
      if (rd_ptr != wr_ptr) begin
        fifo_q <= mem[rd_ptr];
        rd_ptr++;
      end
    end
  end

  always @(negedge clk) fifo_empty = (rd_ptr == wr_ptr);

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic chk_digit(input int i, input logic [7:0] exp);
    logic [5:0] want;
    int n;
    want = ~(6'b000001 << i);
    n = 0;
    while (seg_sel !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk($sformatf("scan_to%0d", i), {26'd0, seg_sel}, {26'd0, want});
    else chk($sformatf("dig%0d", i), {24'd0, seg_led}, {24'd0, exp});
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    chk("rst_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("rst_err", {31'd0, byte_err}, 32'd0);
    chk("rst_sel", {26'd0, seg_sel}, 32'h3F);
    chk("rst_led", {24'd0, seg_led}, 32'hFF);

    // Scan rotation with an empty FIFO: each digit held 4 cycles
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      int idx;
      @(negedge clk);
      idx = ((k - 1) / 4) % 6;
      chk($sformatf("scan_sel%0d", k), {26'd0, seg_sel}, {26'd0, ~(6'b000001 << idx)});
      chk($sformatf("scan_led%0d", k), {24'd0, seg_led}, (idx == 0) ? 32'hC0 : {24'd0, LZ});
    end
    chk("no_pop", pop_cnt, 0);

    // '1','2','3' with exact first-pop latency
    @(posedge clk);
    #1;
    push(8'h31); push(8'h32); push(8'h33);
    @(negedge clk);
    chk("lat_n0_rd", {31'd0, fifo_rdreq}, 32'd0);
    @(negedge clk);
    chk("lat_n1_rd", {31'd0, fifo_rdreq}, 32'd1);
    @(negedge clk);
    chk("lat_n2_rd", {31'd0, fifo_rdreq}, 32'd0);
    @(negedge clk);
    chk("lat_n3_bcd", {8'd0, disp_bcd}, 32'h0);
    @(negedge clk);
    chk("lat_n4_bcd", {8'd0, disp_bcd}, 32'h1);
    repeat (12) @(negedge clk);
    chk("bcd_123", {8'd0, disp_bcd}, 32'h000123);
    chk("pops_3", pop_cnt, 3);
    chk_digit(0, 8'hB0);
    chk_digit(1, 8'hA4);
    chk_digit(2, 8'hF9);
    chk_digit(3, LZ);

    // 'C' then seven digits '1'..'7'
    @(posedge clk);
    #1;
    push(8'h43); push(8'h31);
    repeat (12) @(negedge clk);
    chk("bcd_clr1", {8'd0, disp_bcd}, 32'h000001);
    @(posedge clk);
    #1;
    for (int d = 2; d <= 7; d++) push(8'h30 + 8'(d));
    repeat (30) @(negedge clk);
    chk("bcd_7dig", {8'd0, disp_bcd}, 32'h234567);
    chk("ndig_sat", {29'd0, dut.ndig_q}, 32'd6);
    chk_digit(5, 8'hA4);
    chk_digit(0, 8'hF8);

    // 'x' then CR
    @(posedge clk);
    #1;
    push(8'h78); push(8'h0D);
    repeat (12) @(negedge clk);
    chk("bcd_bad", {8'd0, disp_bcd}, 32'h234567);
    chk("err_once", err_cnt, 1);
    chk("pops_13", pop_cnt, 13);

    // '9','8' then 'c'
    @(posedge clk);
    #1;
    push(8'h39); push(8'h38);
    repeat (12) @(negedge clk);
    chk("bcd_98", {8'd0, disp_bcd}, 32'h456798);
    @(posedge clk);
    #1;
    push(8'h63);
    repeat (8) @(negedge clk);
    chk("bcd_clr", {8'd0, disp_bcd}, 32'h0);
    chk("ndig_clr", {29'd0, dut.ndig_q}, 32'd0);
    chk_digit(0, 8'hC0);
    chk_digit(1, LZ);
    chk_digit(5, LZ);
    chk("err_still1", err_cnt, 1);

    // Reset asserted the cycle after rdreq
    @(posedge clk);
    #1;
    push(8'h35);
    repeat (8) @(negedge clk);
    chk("bcd_5", {8'd0, disp_bcd}, 32'h5);
    @(posedge clk);
    #1;
    push(8'h34);
    n = 0;
    while (fifo_rdreq !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rdreq_seen", {31'd0, fifo_rdreq}, 32'd1);
    @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    chk("mid_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("mid_err", {31'd0, byte_err}, 32'd0);
    chk("mid_sel", {26'd0, seg_sel}, 32'h3F);
    chk("mid_led", {24'd0, seg_led}, 32'hFF);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("post_bcd", {8'd0, disp_bcd}, 32'h0);
    chk("post_pops", pop_cnt, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
